// File: rtl/hb_mon_pkg.sv
// Shared types and constants for the heartbeat monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hb_mon_pkg;

   // Monitor state: waiting for a first edge, acquiring lock, locked, sticky fault
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

   // fault_code values
   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_SHORT   = 2'd1;
   localparam logic [1:0] FC_LONG    = 2'd2;
   localparam logic [1:0] FC_TIMEOUT = 2'd3;

   // Cycles after reset release during which edges are ignored
   localparam int PRIME_LEN = 4;

endpackage

// File: rtl/hb_sync_edge.sv
// Synchronizes the async heartbeat line and flags either-polarity edges.
// Latency: hb_in change -> edge_pulse visible 2 cycles later, consumed on the 3rd edge.
// Backpressure: none; edge_pulse is a single-cycle strobe.
module hb_sync_edge
   import hb_mon_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic hb_in,
   output logic edge_pulse
);

   logic       sync1;
   logic       sync2;
   logic       sync3;
   logic [2:0] prime_cnt;
   logic       primed;

   // Primed once PRIME_LEN cycles have elapsed since reset release; this masks the
   // spurious edge when the line is already high as the zero-reset sync flops fill.
   assign primed     = (prime_cnt == 3'(PRIME_LEN));
   assign edge_pulse = primed && (sync2 != sync3);

   // Two-flop synchronizer, delayed copy for edge detect, and priming counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync3     <= 1'b0;
         prime_cnt <= '0;
      end else begin
         sync1 <= hb_in;
         sync2 <= sync1;
         sync3 <= sync2;
         if (!primed)
            prime_cnt <= prime_cnt + 3'd1;
      end
   end

endmodule

// File: rtl/led_heartbeat_monitor.sv
// Measures heartbeat edge intervals, declares lock, and latches sticky faults.
// Latency: outputs update on the edge-detect cycle (3 cycles after hb_in changes).
// Backpressure: none; clr_fault is a single-cycle pulse honoured only in FAULT.
module led_heartbeat_monitor
   import hb_mon_pkg::*;
#(
   parameter int EXP_INTERVAL = 1001,
   parameter int TOL          = 2,
   parameter int LOCK_COUNT   = 4,
   parameter int CNT_W        = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hb_in,
   input  logic             clr_fault,
   output logic             locked,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] last_interval,
   output logic [15:0]      edge_count
);

   localparam int                GW      = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] LO_LIM  = CNT_W'(EXP_INTERVAL - TOL);
   localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(EXP_INTERVAL + TOL);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(2 * EXP_INTERVAL);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [GW-1:0]    good_cnt;
   logic             edge_pulse;
   logic [CNT_W-1:0] meas;
   logic             is_short;
   logic             is_long;
   logic             timeout;

   hb_sync_edge u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .hb_in      (hb_in),
      .edge_pulse (edge_pulse)
   );

   // Interval as seen on this cycle; a saturated counter stays saturated so it
   // classifies as long instead of wrapping to a small value.
   assign meas     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
   assign is_short = (meas < LO_LIM);
   assign is_long  = (meas > HI_LIM);
   // An edge on the threshold cycle takes precedence and is classified instead
   assign timeout  = !edge_pulse && (meas == TO_LIM);

   // Lock/fault FSM with interval counter, classifier and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         good_cnt      <= '0;
         locked        <= 1'b0;
         fault         <= 1'b0;
         fault_code    <= FC_NONE;
         last_interval <= '0;
         edge_count    <= '0;
      end else begin
         if (edge_pulse)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);

         case (state)
            ST_FAULT: begin
               // Clear beats a coincident edge: that edge is simply dropped
               if (clr_fault) begin
                  state      <= ST_IDLE;
                  fault      <= 1'b0;
                  fault_code <= FC_NONE;
                  edge_count <= '0;
                  cnt        <= '0;
                  good_cnt   <= '0;
               end
            end
            default: begin
               if (edge_pulse) begin
                  if (edge_count != 16'hFFFF)
                     edge_count <= edge_count + 16'd1;
                  if (state == ST_IDLE) begin
                     // First edge only starts the measurement window
                     state    <= ST_ACQ;
                     good_cnt <= '0;
                  end else if (is_short || is_long) begin
                     state         <= ST_FAULT;
                     fault         <= 1'b1;
                     locked        <= 1'b0;
                     fault_code    <= is_short ? FC_SHORT : FC_LONG;
                     last_interval <= meas;
                  end else begin
                     last_interval <= meas;
                     if (state == ST_ACQ) begin
                        good_cnt <= good_cnt + GW'(1);
                        if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                           state  <= ST_LOCKED;
                           locked <= 1'b1;
                        end
                     end
                  end
               end else if (timeout) begin
                  state      <= ST_FAULT;
                  fault      <= 1'b1;
                  locked     <= 1'b0;
                  fault_code <= FC_TIMEOUT;
               end
            end
         endcase
      end
   end

endmodule
